spi_cmd_controller: RTL
=======================

Name: spi_cmd_controller

Overview:
Frame parser and sequencer between the SPI slave byte stream and the mixer configuration register bank. Collects opcode and payload bytes from the MCU, assembles them into one register write, and presents it on a valid/ready port to the register bank. Enforces frame boundaries using slave-select and an inter-byte timeout. Counts protocol errors for debug readout.

Parameters:
DATA_W, 16, payload/config data width; must be 16 (two payload bytes max)
ADDR_W, 6, config register address width (opcode[5:0])
TIMEOUT_CYCLES, 65535, clk cycles allowed between bytes inside a frame; minimum 2

Ports:
clk  in  1  system clock; spi_ss sampled here, byte_in/byte_valid come from the SPI slave on this clock
rst_n  in  1  reset, asynchronous assert, active low
spi_ss  in  1  SPI slave select, active low; already synchronised to clk
byte_in  in  8  received byte
byte_valid  in  1  one-cycle strobe, byte_in valid
cfg_valid  out  1  register write pending
cfg_ready  in  1  register bank accepts the write
cfg_addr  out  ADDR_W  register address
cfg_data  out  DATA_W  register data, right-aligned
busy  out  1  frame in progress (state != IDLE)
err_count  out  8  saturating protocol error counter

Behaviour:
- Reset (async, rst_n=0): state IDLE; cfg_valid=0, cfg_addr=0, cfg_data=0, busy=0, err_count=0, timeout counter=0, overflow flag=0.
- Opcode byte: [7:6] length code: 00 = 1 payload byte, 01 = 2 payload bytes, 10 = 0 payload bytes (strobe, data=0), 11 = reserved. [5:0] = address.
- Payload is MSB first. A 1-byte payload is zero-extended into cfg_data[7:0].
- IDLE: byte_valid with spi_ss=0:
  - length 10 -> COMMIT.
  - length 00/01 -> PAYLOAD; latch address; remaining count = 1/2; clear data.
  - length 11 -> err_count+1, go to DISCARD.
- PAYLOAD: each byte_valid shifts data left 8 and inserts byte_in, then decrements the remaining count. The last byte -> COMMIT in the following cycle.
- COMMIT: cfg_valid=1; cfg_addr/cfg_data stay stable until the handshake. When cfg_valid and cfg_ready are both 1, cfg_valid drops the next cycle. Next state is IDLE, or DISCARD if the overflow flag is set (flag clears on exit).
- DISCARD: ignore all bytes. Return to IDLE when spi_ss=1.
- Latency: last byte strobe -> cfg_valid high = 1 cycle. With cfg_ready held high, cfg_valid is high for exactly 1 cycle.
- Multiple frames are allowed back to back within one spi_ss-low window.
- Timeout: the counter runs only in PAYLOAD and resets on every byte_valid. On reaching TIMEOUT_CYCLES-1: err_count+1, go to DISCARD.
- spi_ss=1 during PAYLOAD: abort; err_count+1; go to IDLE; no commit.
- spi_ss=1 during COMMIT: commit still completes normally.
- byte_valid during COMMIT: byte is dropped; err_count+1; overflow flag set.
- spi_ss=1 in IDLE: no effect. byte_valid with spi_ss=1 is ignored in every state.
- err_count saturates at 255. It increments by at most 1 per cycle.
- busy = (state != IDLE).

Optional Feature:
SPI_CMD_CHECKSUM_EN:
- Defined: every frame carries one trailing check byte equal to the XOR of the opcode and all payload bytes; a CHECK state sits between PAYLOAD and COMMIT. The strobe opcode also carries a check byte. Match -> COMMIT. Mismatch -> err_count+1, DISCARD, no write. The timeout also applies in CHECK. Commit latency is measured from the check byte.
- Undefined: no check byte; behaviour exactly as above.

Decomposition:
- Package spi_cmd_pkg: state enum (IDLE, PAYLOAD, CHECK, COMMIT, DISCARD), length-code constants (LEN_1, LEN_2, LEN_STROBE, LEN_RSVD), DATA_W/ADDR_W defaults.
- One natural sub-module: spi_cmd_timeout. It is a loadable down-counter with clear, enable and an expired pulse, reused later for other MCU links.

Test Plan:
- Opcode 0x45 then 0x12, 0x34, cfg_ready=1 -> one cfg_valid pulse 1 cycle after 0x34; addr=0x05, data=0x1234; err_count=0.
- Opcode 0x03 then 0xAB, cfg_ready=0 for 5 cycles -> cfg_valid held with addr=0x03, data=0x00AB; drops the cycle after ready. A 3rd byte during the wait -> err_count=1, then DISCARD until spi_ss=1.
- Opcode 0x80 -> strobe write addr=0x00, data=0x0000. Opcode 0xC1 -> err_count+1, no write, following bytes ignored until spi_ss high.
- Opcode 0x41, 0x55, then spi_ss=1 -> no write, err_count=1, state IDLE. Repeat with a TIMEOUT_CYCLES=16 stall -> err_count=2, DISCARD.
- rst_n pulled low mid-PAYLOAD (asynchronously, between clk edges) -> outputs 0 immediately. A new frame 0x02, 0x7F afterwards -> addr=0x02, data=0x007F.
- With SPI_CMD_CHECKSUM_EN: 0x45, 0x12, 0x34, 0x63 -> write 0x1234. Check byte 0x00 instead -> no write, err_count=1.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared types and constants for the SPI command frame parser.
package spi_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PAYLOAD,
      CHECK,
      COMMIT,
      DISCARD
   } state_e;

   localparam logic [1:0] LEN_1      = 2'b00;
   localparam logic [1:0] LEN_2      = 2'b01;
   localparam logic [1:0] LEN_STROBE = 2'b10;
   localparam logic [1:0] LEN_RSVD   = 2'b11;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 6;

endpackage

// File: rtl/spi_cmd_timeout.sv
// spi_cmd_timeout: loadable down-counter; expired pulses while enabled at zero with no reload.
module spi_cmd_timeout #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         clr,
   input  logic         en,
   output logic         expired
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = load ? load_val :
              clr  ? '0 :
              (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign expired = en && !load && !clr && cnt_q == '0;

endmodule

// File: rtl/spi_cmd_controller.sv
// spi_cmd_controller: turns SPI opcode/payload bytes into one config register write.
// Define SPI_CMD_CHECKSUM_EN to require a trailing XOR check byte on every frame.
module spi_cmd_controller
   import spi_cmd_pkg::*;
#(
   parameter int DATA_W         = DATA_W_DEF,
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_ss,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              cfg_valid,
   input  logic              cfg_ready,
   output logic [ADDR_W-1:0] cfg_addr,
   output logic [DATA_W-1:0] cfg_data,
   output logic              busy,
   output logic [7:0]        err_count
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);

   // State that follows the final payload byte (or a strobe opcode).
`ifdef SPI_CMD_CHECKSUM_EN
   localparam state_e POST = CHECK;
`else
   localparam state_e POST = COMMIT;
`endif

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [1:0]        rem_q, rem_d;
   logic [7:0]        err_q, err_d;
   logic              ovf_q, ovf_d;
   logic              err_inc, acc, timed, expired;
`ifdef SPI_CMD_CHECKSUM_EN
   logic [7:0]        chk_q, chk_d;
`endif

   assign acc   = byte_valid && !spi_ss;
   assign timed = state_q == PAYLOAD || state_q == CHECK;

   spi_cmd_timeout #(.W(TW)) u_timeout (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (acc),
      .load_val (TW'(TIMEOUT_CYCLES - 1)),
      .clr      (!timed),
      .en       (timed),
      .expired  (expired)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rem_d   = rem_q;
      ovf_d   = ovf_q;
      err_inc = 1'b0;
`ifdef SPI_CMD_CHECKSUM_EN
      chk_d   = chk_q;
`endif
      unique case (state_q)
         IDLE: if (acc) begin
            if (byte_in[7:6] == LEN_RSVD) begin
               err_inc = 1'b1;
               state_d = DISCARD;
            end else begin
               addr_d  = byte_in[ADDR_W-1:0];
               data_d  = '0;
               rem_d   = byte_in[7:6] == LEN_2 ? 2'd2 : 2'd1;
               state_d = byte_in[7:6] == LEN_STROBE ? POST : PAYLOAD;
            end
`ifdef SPI_CMD_CHECKSUM_EN
            chk_d = byte_in;
`endif
         end
         PAYLOAD: if (spi_ss) begin
            err_inc = 1'b1;
            state_d = IDLE;
         end else if (acc) begin
            data_d = {data_q[DATA_W-9:0], byte_in};
            rem_d  = rem_q - 2'd1;
            if (rem_q == 2'd1) state_d = POST;
`ifdef SPI_CMD_CHECKSUM_EN
            chk_d = chk_q ^ byte_in;
`endif
         end else if (expired) begin
            err_inc = 1'b1;
            state_d = DISCARD;
         end
`ifdef SPI_CMD_CHECKSUM_EN
         CHECK: if (spi_ss) begin
            err_inc = 1'b1;
            state_d = IDLE;
         end else if (acc) begin
            err_inc = byte_in != chk_q;
            state_d = byte_in == chk_q ? COMMIT : DISCARD;
         end else if (expired) begin
            err_inc = 1'b1;
            state_d = DISCARD;
         end
`else
         CHECK: state_d = IDLE;
`endif
         // A byte arriving while the write waits is lost; the rest of the frame is then junk.
         COMMIT: begin
            err_inc = acc;
            if (cfg_ready) begin
               state_d = (ovf_q || acc) ? DISCARD : IDLE;
               ovf_d   = 1'b0;
            end else if (acc) begin
               ovf_d = 1'b1;
            end
         end
         DISCARD: if (spi_ss) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         rem_q   <= '0;
         err_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef SPI_CMD_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chk_q <= '0;
      else        chk_q <= chk_d;
   end
`endif

   assign cfg_valid = state_q == COMMIT;
   assign cfg_addr  = addr_q;
   assign cfg_data  = data_q;
   assign busy      = state_q != IDLE;
   assign err_count = err_q;

endmodule
